// File: rtl/fetch_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl_if
// Bundles every handshake and data signal of the SEQ fetch controller.
//   PC side     : pc_in, pc_valid (to controller), pc_ready (from controller)
//   Memory side : mem_req, mem_addr (from controller), mem_ack, mem_rdata (to it)
//   Decode side : icode, ifun, rA, rB, valC, valP, imem_error, func_error,
//                 halt, nop, instr_valid (from controller), instr_ready (to it)
// modport master : the fetch controller itself
// modport slave  : whatever surrounds it (PC logic, memory, decode stage)
// -----------------------------------------------------------------------------
interface fetch_seq_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [ADDR_W-1:0] valC;
  logic [ADDR_W-1:0] valP;
  logic              imem_error;
  logic              func_error;
  logic              halt;
  logic              nop;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    input  pc_in, pc_valid, mem_ack, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, icode, ifun, rA, rB, valC, valP,
           imem_error, func_error, halt, nop, instr_valid
  );

  modport slave (
    output pc_in, pc_valid, mem_ack, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, icode, ifun, rA, rB, valC, valP,
           imem_error, func_error, halt, nop, instr_valid
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl
// Multi-cycle fetch controller for the SEQ core. Takes a PC, reads the
// instruction one byte per mem_req/mem_ack handshake, assembles the decoded
// fields and valP, and offers them to decode with instr_valid/instr_ready.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : fetch_seq_ctrl_if.master (PC, memory and decode handshakes)
// Timing with mem_ack tied high: PC accepted at edge 0, bytes captured at
// edges 1..L, instr_valid visible after edge L, next PC accepted at edge L+2.
// -----------------------------------------------------------------------------
module fetch_seq_ctrl #(
  parameter int IMEM_SIZE = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_seq_ctrl_if.master      bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_DONE, S_HALTED} state_t;

  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_SIZE);

  // Instruction length from icode; 0 marks an illegal icode.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        len_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_ready_q, mem_req_q, instr_valid_q;
  logic [ADDR_W-1:0] mem_addr_q, valc_q, valp_q;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic              imem_error_q, func_error_q, halt_q, nop_q;

  logic [3:0]        len_d, nxt_cnt_d;
  logic              last_d, nxt_oor_d, reg_byte_d, pc_in_oor_d;
  logic [2:0]        const_idx_d;
  logic [ADDR_W-1:0] nxt_addr_d, valc_d;

  // Byte-position bookkeeping for the byte arriving this cycle.
  always_comb begin
    // On the first byte the length comes straight from the returned icode.
    len_d       = (cnt_q == 4'd0) ? instr_len(bus.mem_rdata[7:4]) : len_q;
    nxt_cnt_d   = cnt_q + 4'd1;
    last_d      = (nxt_cnt_d == len_d);
    nxt_addr_d  = pc_q + {{(ADDR_W-4){1'b0}}, nxt_cnt_d};
    nxt_oor_d   = (nxt_addr_d >= IMEM_LIMIT);
    pc_in_oor_d = (bus.pc_in >= IMEM_LIMIT);
    reg_byte_d  = (cnt_q == 4'd1) && ((len_q == 4'd2) || (len_q == 4'd10));
    // Constant starts one byte later when a register byte precedes it.
    const_idx_d = (len_q == 4'd10) ? 3'(cnt_q - 4'd2) : 3'(cnt_q - 4'd1);
    valc_d      = valc_q;
    if ((cnt_q != 4'd0) && !reg_byte_d) begin
      valc_d[{const_idx_d, 3'b000} +: 8] = bus.mem_rdata;
    end else begin
      valc_d = valc_q;
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      len_q         <= 4'd0;
      pc_q          <= '0;
      pc_ready_q    <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      icode_q       <= 4'd0;
      ifun_q        <= 4'd0;
      ra_q          <= 4'd0;
      rb_q          <= 4'd0;
      valc_q        <= '0;
      valp_q        <= '0;
      imem_error_q  <= 1'b0;
      func_error_q  <= 1'b0;
      halt_q        <= 1'b0;
      nop_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.pc_valid && pc_ready_q) begin
            pc_q         <= bus.pc_in;
            cnt_q        <= 4'd0;
            len_q        <= 4'd0;
            pc_ready_q   <= 1'b0;
            icode_q      <= 4'd0;
            ifun_q       <= 4'd0;
            ra_q         <= 4'd0;
            rb_q         <= 4'd0;
            valc_q       <= '0;
            valp_q       <= '0;
            func_error_q <= 1'b0;
            halt_q       <= 1'b0;
            nop_q        <= 1'b0;
            if (pc_in_oor_d) begin
              imem_error_q  <= 1'b1;
              valp_q        <= bus.pc_in;
              instr_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              imem_error_q <= 1'b0;
              mem_req_q    <= 1'b1;
              mem_addr_q   <= bus.pc_in;
              state_q      <= S_RD;
            end
          end
        end
        S_RD: begin
          if (mem_req_q && bus.mem_ack) begin
            if (cnt_q == 4'd0) begin
              icode_q <= bus.mem_rdata[7:4];
              ifun_q  <= bus.mem_rdata[3:0];
              len_q   <= len_d;
              halt_q  <= (bus.mem_rdata[7:4] == 4'h0);
              nop_q   <= (bus.mem_rdata[7:4] == 4'h1);
            end else if (reg_byte_d) begin
              ra_q <= bus.mem_rdata[7:4];
              rb_q <= bus.mem_rdata[3:0];
            end else begin
              valc_q <= valc_d;
            end
            if (len_d == 4'd0) begin
              // Illegal icode: nxt_addr_d is PC+1 on the first byte.
              func_error_q  <= 1'b1;
              valp_q        <= nxt_addr_d;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else if (last_d) begin
              valp_q        <= pc_q + {{(ADDR_W-4){1'b0}}, len_d};
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else if (nxt_oor_d) begin
              // Next byte lies outside memory: stop without requesting it.
              imem_error_q  <= 1'b1;
              valp_q        <= nxt_addr_d;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              cnt_q      <= nxt_cnt_d;
              mem_addr_q <= nxt_addr_d;
            end
          end
        end
        S_DONE: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (halt_q) begin
              state_q <= S_HALTED;
            end else begin
              state_q      <= S_IDLE;
              pc_ready_q   <= 1'b1;
              imem_error_q <= 1'b0;
              func_error_q <= 1'b0;
              nop_q        <= 1'b0;
            end
          end
        end
        S_HALTED: begin
          // Parked until reset.
          state_q <= S_HALTED;
        end
        default: begin
          state_q       <= S_IDLE;
          pc_ready_q    <= 1'b1;
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_ready    = pc_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.icode       = icode_q;
  assign bus.ifun        = ifun_q;
  assign bus.rA          = ra_q;
  assign bus.rB          = rb_q;
  assign bus.valC        = valc_q;
  assign bus.valP        = valp_q;
  assign bus.imem_error  = imem_error_q;
  assign bus.func_error  = func_error_q;
  assign bus.halt        = halt_q;
  assign bus.nop         = nop_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq_ctrl
// Drives directed and randomized fetches into fetch_seq_ctrl and compares every
// cycle against a transaction-level model: at each accepted PC the expected
// instruction is decoded straight from the memory array, and the model then
// only tracks which phase the fetch is in and how many bytes have been acked.
// -----------------------------------------------------------------------------
module tb_fetch_seq_ctrl;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DONE = 2, PH_HALT = 3;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        imem, func, halt, nop;
    int          nreq;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] imem [1024];
  int         vectors = 0;
  int         errors  = 0;

  fetch_seq_ctrl_if #(.ADDR_W(64)) bus ();

  fetch_seq_ctrl #(.IMEM_SIZE(1024), .ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte-wide memory: returns the byte at whatever address is being requested.
  always_comb begin
    if (bus.mem_addr < 64'd1024) bus.mem_rdata = imem[bus.mem_addr[9:0]];
    else                         bus.mem_rdata = 8'hEE;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode of one instruction at pc, straight from the memory array.
  function automatic res_t decode(input logic [63:0] pc);
    res_t r;
    int len, cbase;
    logic [63:0] a;
    logic [7:0] b;
    r = '0;
    if (pc >= 64'd1024) begin
      r.imem = 1'b1; r.valp = pc; r.nreq = 0;
      return r;
    end
    b = imem[pc[9:0]];
    r.icode = b[7:4]; r.ifun = b[3:0]; r.nreq = 1;
    case (int'(b[7:4]))
      0, 1, 9:        len = 1;
      2, 6, 10, 11:   len = 2;
      3, 4, 5:        len = 10;
      7, 8:           len = 9;
      default:        len = 0;
    endcase
    if (len == 0) begin
      r.func = 1'b1; r.valp = pc + 64'd1;
      return r;
    end
    r.halt = (b[7:4] == 4'h0);
    r.nop  = (b[7:4] == 4'h1);
    cbase  = (len == 10) ? 2 : 1;
    for (int k = 1; k < len; k++) begin
      a = pc + 64'(k);
      if (a >= 64'd1024) begin
        r.imem = 1'b1; r.valp = a;
        return r;
      end
      b = imem[a[9:0]];
      r.nreq = k + 1;
      if (k == 1 && (len == 2 || len == 10)) {r.ra, r.rb} = b;
      else r.valc[8*(k-cbase) +: 8] = b;
    end
    r.valp = pc + 64'(len);
    return r;
  endfunction

  function automatic int first_phase(input logic [63:0] pc);
    res_t r;
    r = decode(pc);
    return (r.nreq == 0) ? PH_DONE : PH_FETCH;
  endfunction

  // Model state: phase, accepted PC, expected result, bytes acked so far.
  int          m_phase = PH_IDLE;
  int          m_idx   = 0;
  logic [63:0] m_pc    = '0;
  res_t        m_res   = '0;

  // Model advance on the same edges the DUT sees.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= PH_IDLE;
      m_idx   <= 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (bus.pc_valid) begin
          m_pc    <= bus.pc_in;
          m_res   <= decode(bus.pc_in);
          m_idx   <= 0;
          m_phase <= first_phase(bus.pc_in);
        end
        PH_FETCH: if (bus.mem_ack) begin
          if (m_idx + 1 == m_res.nreq) m_phase <= PH_DONE;
          else m_idx <= m_idx + 1;
        end
        PH_DONE: if (bus.instr_ready) m_phase <= m_res.halt ? PH_HALT : PH_IDLE;
        default: m_phase <= m_phase;
      endcase
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    chk("pc_ready",    bus.pc_ready,    64'(m_phase == PH_IDLE));
    chk("mem_req",     bus.mem_req,     64'(m_phase == PH_FETCH));
    chk("instr_valid", bus.instr_valid, 64'(m_phase == PH_DONE));
    chk("halt",        bus.halt,        64'((m_phase == PH_DONE && m_res.halt) || m_phase == PH_HALT));
    chk("imem_error",  bus.imem_error,  64'(m_phase == PH_DONE && m_res.imem));
    chk("func_error",  bus.func_error,  64'(m_phase == PH_DONE && m_res.func));
    chk("nop",         bus.nop,         64'(m_phase == PH_DONE && m_res.nop));
    if (m_phase == PH_FETCH) chk("mem_addr", bus.mem_addr, m_pc + 64'(m_idx));
    if (m_phase == PH_DONE) begin
      chk("icode", bus.icode, m_res.icode);
      chk("ifun",  bus.ifun,  m_res.ifun);
      chk("rA",    bus.rA,    m_res.ra);
      chk("rB",    bus.rB,    m_res.rb);
      chk("valC",  bus.valC,  m_res.valc);
      chk("valP",  bus.valP,  m_res.valp);
    end
  end

  // One complete fetch: offer pc, serve bytes with ack_d wait cycles
  // (-1 = random waits plus stray acks), then hold instr_ready low rdy_d cycles.
  task automatic do_fetch(input logic [63:0] pc, input int ack_d, input int rdy_d,
                          input bit noise, output res_t got, output int lat);
    int bound, wcnt, cur_d;
    got = '0; lat = 0; wcnt = 0;
    cur_d = (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
    bound = 0;
    while (bus.pc_ready !== 1'b1 && bound < 50) begin
      @(negedge clk); bound++;
    end
    if (bus.pc_ready !== 1'b1) chk("pc_ready_timeout", bus.pc_ready, 64'd1);
    bus.pc_in = pc; bus.pc_valid = 1'b1; bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      bus.pc_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) bus.pc_in = {$urandom, $urandom};
      if (bus.instr_valid === 1'b1) break;
      if (lat > 300) begin
        chk("valid_timeout", bus.instr_valid, 64'd1);
        break;
      end
      if (bus.mem_req === 1'b1) begin
        if (wcnt >= cur_d) begin
          bus.mem_ack = 1'b1; wcnt = 0; got.nreq++;
          cur_d = (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
        end else begin
          bus.mem_ack = 1'b0; wcnt++;
        end
      end else begin
        bus.mem_ack = (ack_d < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    got.icode = bus.icode; got.ifun = bus.ifun; got.ra = bus.rA; got.rb = bus.rB;
    got.valc = bus.valC; got.valp = bus.valP; got.imem = bus.imem_error;
    got.func = bus.func_error; got.halt = bus.halt; got.nop = bus.nop;
    repeat (rdy_d) @(negedge clk);
    bus.instr_ready = 1'b1; bus.pc_valid = 1'b0;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  res_t got;
  int   lat;

  initial begin
    logic [7:0] irm [10];
    logic [7:0] b;
    logic [63:0] pc;
    int r;
    irm = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 1024; i++) imem[i] = 8'h10;
    bus.pc_in = '0; bus.pc_valid = 1'b0; bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc_ready",    bus.pc_ready,    64'd1);
    chk("rst_mem_req",     bus.mem_req,     64'd0);
    chk("rst_instr_valid", bus.instr_valid, 64'd0);
    chk("rst_valP",        bus.valP,        64'd0);
    reset = 1'b0;
    @(negedge clk);

    // irmovq, ack tied high
    for (int i = 0; i < 10; i++) imem[16 + i] = irm[i];
    do_fetch(64'h10, 0, 0, 1'b0, got, lat);
    chk("irm_icode", got.icode, 64'h3);
    chk("irm_ifun",  got.ifun,  64'h0);
    chk("irm_rA",    got.ra,    64'hF);
    chk("irm_rB",    got.rb,    64'h3);
    chk("irm_valC",  got.valc,  64'h0102030405060708);
    chk("irm_valP",  got.valp,  64'h1A);
    chk("irm_nreq",  64'(got.nreq), 64'd10);
    chk("irm_lat",   64'(lat),  64'd11);

    // call with slow memory and slow decode
    imem[32] = 8'h80;
    for (int i = 1; i < 9; i++) imem[32 + i] = (i == 2) ? 8'h01 : 8'h00;
    do_fetch(64'h20, 3, 5, 1'b1, got, lat);
    chk("call_valC", got.valc, 64'h100);
    chk("call_valP", got.valp, 64'h29);

    // top-of-memory boundaries
    imem[1020] = 8'h60; imem[1021] = 8'h12;
    do_fetch(64'h3FC, 0, 0, 1'b0, got, lat);
    chk("opq_valP", got.valp, 64'h3FE);
    chk("opq_imem", got.imem, 64'd0);
    chk("opq_rArB", {got.ra, got.rb}, 64'h12);
    imem[1023] = 8'h30;
    do_fetch(64'h3FF, 0, 0, 1'b0, got, lat);
    chk("edge_imem", got.imem, 64'd1);
    chk("edge_valP", got.valp, 64'h400);
    chk("edge_nreq", 64'(got.nreq), 64'd1);
    do_fetch(64'd2000, 0, 0, 1'b0, got, lat);
    chk("far_imem", got.imem, 64'd1);
    chk("far_valP", got.valp, 64'd2000);
    chk("far_nreq", 64'(got.nreq), 64'd0);

    // illegal icode
    imem[0] = 8'hC5;
    do_fetch(64'h0, 0, 1, 1'b0, got, lat);
    chk("ill_func",  got.func,  64'd1);
    chk("ill_icode", got.icode, 64'hC);
    chk("ill_ifun",  got.ifun,  64'h5);
    chk("ill_valP",  got.valp,  64'h1);

    // randomized traffic over a halt-free memory image
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'h0) b[7:4] = 4'h1;
      imem[i] = b;
    end
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85)      pc = 64'($urandom_range(0, 1023));
      else if (r < 93) pc = 64'($urandom_range(1000, 1100));
      else if (r < 97) pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else             pc = {$urandom, $urandom};
      do_fetch(pc, (n % 2 == 0) ? -1 : int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'b1, got, lat);
    end

    // halt parks the controller
    imem[1] = 8'h00;
    do_fetch(64'h1, 0, 0, 1'b0, got, lat);
    chk("halt_flag", got.halt, 64'd1);
    bus.pc_in = 64'h0; bus.pc_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("halted_pc_ready", bus.pc_ready, 64'd0);
      chk("halted_halt",     bus.halt,     64'd1);
    end
    bus.pc_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset in the middle of a fetch, then a fresh nop
    for (int i = 0; i < 10; i++) imem[16 + i] = irm[i];
    bus.pc_in = 64'h10; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_req",     bus.mem_req,     64'd0);
    chk("midrst_instr_valid", bus.instr_valid, 64'd0);
    chk("midrst_pc_ready",    bus.pc_ready,    64'd1);
    @(negedge clk);
    reset = 1'b0; bus.mem_ack = 1'b0;
    imem[5] = 8'h10;
    do_fetch(64'h5, 0, 0, 1'b0, got, lat);
    chk("nop_valP", got.valp, 64'h6);
    chk("nop_valC", got.valc, 64'h0);
    chk("nop_flag", got.nop,  64'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
